// File: rtl/data_memory_storer.sv
// Store engine for a 32-bit memory without byte enables: word stores write directly,
// byte/half stores read-modify-write. Accept-to-done latency is 2 cycles for a word and 3+READ_LATENCY for a sub-word.
// No backpressure: start_in is only sampled in IDLE and busy_out flags the non-accepting states.
module data_memory_storer #(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        start_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] data_in,
    input  logic [1:0]  size_in,
    input  logic [31:0] mem_rdata_in,
    output logic [31:0] mem_addr_out,
    output logic        mem_rd_out,
    output logic        mem_wr_out,
    output logic [31:0] mem_wdata_out,
    output logic        busy_out,
    output logic        done_out,
    output logic        error_out
);

    localparam logic [3:0] LAST_WAIT = 4'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        ERROR = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] addr_q, data_q, wdata_q, merged;
    logic [1:0]  size_q;
    logic [3:0]  wait_cnt;
    logic        done_q;
    logic        accept, misaligned, wait_last;

    assign accept    = (state == IDLE) && start_in;
    assign wait_last = (wait_cnt == LAST_WAIT);

    // Size 10 is reserved and handled exactly like a word store.
    always_comb begin
        misaligned = 1'b0;
        case (size_in)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = addr_in[0];
            default: misaligned = |addr_in[1:0];
        endcase
    end

    // Only the addressed little-endian lane is replaced; the rest comes from the read.
    always_comb begin
        merged = mem_rdata_in;
        if (size_q == 2'b01) begin
            if (addr_q[1]) merged[31:16] = data_q[15:0];
            else           merged[15:0]  = data_q[15:0];
        end else begin
            case (addr_q[1:0])
                2'b00: merged[7:0]   = data_q[7:0];
                2'b01: merged[15:8]  = data_q[7:0];
                2'b10: merged[23:16] = data_q[7:0];
                2'b11: merged[31:24] = data_q[7:0];
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_in) begin
                    if (misaligned)       state_nxt = ERROR;
                    else if (size_in[1])  state_nxt = WRITE;
                    else                  state_nxt = READ;
                end
            end
            READ:    state_nxt = WAIT;
            WAIT:    state_nxt = wait_last ? WRITE : WAIT;
            WRITE:   state_nxt = IDLE;
            ERROR:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            addr_q   <= '0;
            data_q   <= '0;
            size_q   <= '0;
            wdata_q  <= '0;
            wait_cnt <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= (state == WRITE);
            if (accept) begin
                addr_q   <= addr_in;
                data_q   <= data_in;
                size_q   <= size_in;
                wait_cnt <= '0;
            end
            if (state == WAIT) begin
                wait_cnt <= wait_cnt + 4'd1;
                if (wait_last) wdata_q <= merged;
            end
        end
    end

    always_comb begin
        mem_addr_out  = {addr_q[31:2], 2'b00};
        mem_rd_out    = (state == READ);
        mem_wr_out    = (state == WRITE);
        mem_wdata_out = '0;
        if (state == WRITE) mem_wdata_out = size_q[1] ? data_q : wdata_q;
        busy_out      = (state != IDLE);
        done_out      = done_q;
        error_out     = (state == ERROR);
    end

endmodule
